// File: rtl/dram_pkg.sv
// Shared command encoding and width helpers for the multi-bank DRAM model.
package dram_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4
  } cmd_e;

  localparam int BYTE_W     = 8;
  localparam int TRCD_CNT_W = 4;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic cmd_e decode_cmd(input logic csn, input logic rasn,
                                      input logic casn, input logic wr_any);
    cmd_e cmd;
    cmd = NOP;
    if (csn) begin
      cmd = NOP;
    end else begin
      case ({rasn, casn})
        2'b01:   cmd = ACT;
        2'b00:   cmd = wr_any ? WR : RD;
        2'b10:   cmd = PRE;
        default: cmd = NOP;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// CL-deep valid/data delay line for read returns; data is forced to zero when invalid.
module dram_rd_pipe #(
  parameter int WORD_W = 32,
  parameter int CL     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data
);

  logic [CL-1:0]     v_r;
  logic [WORD_W-1:0] d_r [CL];

  // shift register; stage 0 takes the new read, the last stage drives the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
      for (int i = 0; i < CL; i++) d_r[i] <= '0;
    end else begin
      v_r[0] <= in_valid;
      d_r[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < CL; i++) begin
        v_r[i] <= v_r[i-1];
        d_r[i] <= d_r[i-1];
      end
    end
  end

  assign out_valid = v_r[CL-1];
  assign out_data  = d_r[CL-1];

endmodule

// File: rtl/dram_multibank.sv
// Multi-bank DRAM behavioural model: per-bank open row and tRCD tracking,
// byte-lane storage indexed by {bank, row, col}, and a fixed-latency read return.
module dram_multibank
  import dram_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROW_W  = 12,
  parameter int COL_W  = 10,
  parameter int BANK_W = 2,
  parameter int CL     = 3,
  parameter int TRCD   = 2,
  localparam int ADDR_W    = max_w(ROW_W, COL_W),
  localparam int BYTES     = WORD_W / BYTE_W,
  localparam int NUM_BANKS = 1 << BANK_W
) (
  input  logic                 CK,
  input  logic                 RSTn,
  input  logic                 CSn,
  input  logic                 RASn,
  input  logic                 CASn,
  input  logic [BYTES-1:0]     WEn,
  input  logic [BANK_W-1:0]    BA,
  input  logic [ADDR_W-1:0]    A,
  input  logic [WORD_W-1:0]    D,
  output logic [WORD_W-1:0]    Q,
  output logic                 QV,
  output logic [NUM_BANKS-1:0] BANK_OPEN,
  output logic                 CMD_ERR
);

  localparam int IDX_W = BANK_W + ROW_W + COL_W;
  localparam int DEPTH = 1 << IDX_W;
  // The counter holds the wait still owed after the ACT edge, so a column
  // command exactly TRCD cycles after ACT sees zero and is accepted.
  localparam logic [TRCD_CNT_W-1:0] TRCD_LOAD = TRCD_CNT_W'(TRCD - 1);

  logic [NUM_BANKS-1:0]  bank_open_r;
  logic [ROW_W-1:0]      row_r  [NUM_BANKS];
  logic [TRCD_CNT_W-1:0] trcd_r [NUM_BANKS];
  logic                  cmd_err_r;
  logic                  rd_v_r;
  logic [WORD_W-1:0]     rd_d_r;
  logic [WORD_W-1:0]     rd_word_s;
  cmd_e                  cmd_s;
  logic                  col_ok_s;
  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic                  err_s;
  logic [IDX_W-1:0]      idx_s;

  // command decode and legality against the addressed bank's state
  always_comb begin
    cmd_s     = decode_cmd(CSn, RASn, CASn, ~&WEn);
    col_ok_s  = bank_open_r[BA] && (trcd_r[BA] == '0);
    idx_s     = {BA, row_r[BA], A[COL_W-1:0]};
    wr_fire_s = (cmd_s == WR) && col_ok_s;
    rd_fire_s = (cmd_s == RD) && col_ok_s;
    case (cmd_s)
      ACT:     err_s = bank_open_r[BA];
      RD, WR:  err_s = !col_ok_s;
      default: err_s = 1'b0;
    endcase
  end

  // bank state, error pulse and read capture (data sampled at the command edge)
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      bank_open_r <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_r[b]  <= '0;
        trcd_r[b] <= '0;
      end
      cmd_err_r <= 1'b0;
      rd_v_r    <= 1'b0;
      rd_d_r    <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (trcd_r[b] != '0) trcd_r[b] <= trcd_r[b] - TRCD_CNT_W'(1);
      end
      case (cmd_s)
        ACT: begin
          if (!bank_open_r[BA]) begin
            bank_open_r[BA] <= 1'b1;
            row_r[BA]       <= A[ROW_W-1:0];
            trcd_r[BA]      <= TRCD_LOAD;
          end
        end
        PRE:     bank_open_r[BA] <= 1'b0;
        default: ;
      endcase
      cmd_err_r <= err_s;
      rd_v_r    <= rd_fire_s;
      rd_d_r    <= rd_fire_s ? rd_word_s : '0;
    end
  end

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    logic [BYTE_W-1:0] lane [DEPTH];

    // byte lane storage; deliberately not reset
    always_ff @(posedge CK) begin
      if (wr_fire_s && !WEn[i]) lane[idx_s] <= D[BYTE_W*i +: BYTE_W];
    end

    assign rd_word_s[BYTE_W*i +: BYTE_W] = lane[idx_s];
  end

  dram_rd_pipe #(
    .WORD_W (WORD_W),
    .CL     (CL)
  ) u_rd_pipe (
    .clk       (CK),
    .rst_n     (RSTn),
    .in_valid  (rd_v_r),
    .in_data   (rd_d_r),
    .out_valid (QV),
    .out_data  (Q)
  );

  assign BANK_OPEN = bank_open_r;
  assign CMD_ERR   = cmd_err_r;

endmodule

// File: tb/tb_dram_multibank.sv
// Directed bench for dram_multibank with a read-return scoreboard.
module tb_dram_multibank;

  localparam int CL = 3;

  logic        CK = 1'b0;
  logic        RSTn;
  logic        CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [1:0]  BA;
  logic [3:0]  A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        QV;
  logic [3:0]  BANK_OPEN;
  logic        CMD_ERR;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mmem [int];
  logic [3:0]  mrow [4];
  logic [3:0]  mopen;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  dram_multibank #(
    .WORD_W (32), .ROW_W (4), .COL_W (4), .BANK_W (2), .CL (CL), .TRCD (2)
  ) dut (
    .CK (CK), .RSTn (RSTn), .CSn (CSn), .RASn (RASn), .CASn (CASn),
    .WEn (WEn), .BA (BA), .A (A), .D (D), .Q (Q), .QV (QV),
    .BANK_OPEN (BANK_OPEN), .CMD_ERR (CMD_ERR)
  );

  always #5 CK = ~CK;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // read-return monitor: QV must appear exactly at the due cycle with the modelled word
  always @(negedge CK) begin
    logic exp_v;
    while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    chk("qv", {31'd0, QV}, {31'd0, exp_v});
    if (exp_v) begin
      chk("q", Q, sb[0].data);
      void'(sb.pop_front());
    end else begin
      chk("q_idle", Q, 32'd0);
    end
  end

  function automatic int key(input logic [1:0] b, input logic [3:0] r, input logic [3:0] c);
    return (int'(b) << 8) | (int'(r) << 4) | int'(c);
  endfunction

  task automatic step(input logic exp_err);
    @(negedge CK);
    chk("cmd_err", {31'd0, CMD_ERR}, {31'd0, exp_err});
    chk("bank_open", {28'd0, BANK_OPEN}, {28'd0, mopen});
    CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic act(input logic [1:0] b, input logic [3:0] r, input logic exp_err);
    CSn = 1'b0; RASn = 1'b0; CASn = 1'b1; WEn = 4'hF; BA = b; A = r;
    if (!exp_err) begin
      mrow[b]  = r;
      mopen[b] = 1'b1;
    end
    step(exp_err);
  endtask

  task automatic pre(input logic [1:0] b);
    CSn = 1'b0; RASn = 1'b1; CASn = 1'b0; WEn = 4'hF; BA = b; A = 4'd0;
    mopen[b] = 1'b0;
    step(1'b0);
  endtask

  task automatic wr(input logic [1:0] b, input logic [3:0] c, input logic [31:0] d,
                    input logic [3:0] we, input logic exp_err);
    logic [31:0] cur;
    int k;
    CSn = 1'b0; RASn = 1'b0; CASn = 1'b0; WEn = we; BA = b; A = c; D = d;
    if (!exp_err) begin
      k   = key(b, mrow[b], c);
      cur = mmem.exists(k) ? mmem[k] : 32'd0;
      for (int i = 0; i < 4; i++) if (!we[i]) cur[8*i +: 8] = d[8*i +: 8];
      mmem[k] = cur;
    end
    step(exp_err);
  endtask

  task automatic rd(input logic [1:0] b, input logic [3:0] c, input logic exp_err);
    exp_t e;
    CSn = 1'b0; RASn = 1'b0; CASn = 1'b0; WEn = 4'hF; BA = b; A = c;
    if (!exp_err) begin
      e.data = mmem[key(b, mrow[b], c)];
      e.due  = cyc + 1 + CL;
      sb.push_back(e);
    end
    step(exp_err);
  endtask

  initial begin
    RSTn = 1'b0; CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF;
    BA = 2'd0; A = 4'd0; D = 32'd0; mopen = 4'd0;
    for (int b = 0; b < 4; b++) mrow[b] = 4'd0;
    repeat (2) @(negedge CK);
    chk("rst_bank_open", {28'd0, BANK_OPEN}, 32'd0);
    chk("rst_cmd_err", {31'd0, CMD_ERR}, 32'd0);
    RSTn = 1'b1;
    nop(1);

    // basic write then read with CL latency
    act(2'd0, 4'd5, 1'b0);
    nop(1);
    wr(2'd0, 4'd3, 32'hA5A5_1234, 4'b0000, 1'b0);
    rd(2'd0, 4'd3, 1'b0);
    nop(4);

    // byte-masked write; read right after write returns new data
    wr(2'd0, 4'd4, 32'h0000_0000, 4'b0000, 1'b0);
    wr(2'd0, 4'd4, 32'hFFFF_FFFF, 4'b1010, 1'b0);
    rd(2'd0, 4'd4, 1'b0);
    nop(4);
    chk("mask_model", mmem[key(2'd0, 4'd5, 4'd4)], 32'h00FF_00FF);

    // tRCD boundary on bank 1
    act(2'd1, 4'd2, 1'b0);
    nop(1);
    wr(2'd1, 4'd0, 32'hC0DE_0001, 4'b0000, 1'b0);
    pre(2'd1);
    act(2'd1, 4'd2, 1'b0);
    rd(2'd1, 4'd0, 1'b1);
    rd(2'd1, 4'd0, 1'b0);
    nop(4);

    // illegal commands: closed bank, re-ACT of an open bank
    pre(2'd3);
    rd(2'd3, 4'd0, 1'b1);
    nop(1);
    wr(2'd3, 4'd1, 32'hDEAD_BEEF, 4'b0000, 1'b1);
    act(2'd0, 4'd7, 1'b1);
    nop(1);
    rd(2'd0, 4'd3, 1'b0);
    nop(4);

    // interleaved banks, back-to-back reads, PRE while reads are in flight
    act(2'd2, 4'd9, 1'b0);
    nop(1);
    wr(2'd2, 4'd1, 32'h2222_9999, 4'b0000, 1'b0);
    wr(2'd0, 4'd1, 32'h1111_0505, 4'b0000, 1'b0);
    rd(2'd0, 4'd1, 1'b0);
    rd(2'd2, 4'd1, 1'b0);
    rd(2'd0, 4'd3, 1'b0);
    rd(2'd2, 4'd1, 1'b0);
    pre(2'd0);
    nop(4);

    // reset with reads in flight; memory survives reset
    rd(2'd2, 4'd1, 1'b0);
    rd(2'd2, 4'd1, 1'b0);
    RSTn = 1'b0;
    #1;
    chk("rst_qv", {31'd0, QV}, 32'd0);
    chk("rst_q", Q, 32'd0);
    chk("rst_open", {28'd0, BANK_OPEN}, 32'd0);
    chk("rst_err", {31'd0, CMD_ERR}, 32'd0);
    sb.delete();
    mopen = 4'd0;
    repeat (2) @(negedge CK);
    RSTn = 1'b1;
    nop(1);
    act(2'd2, 4'd9, 1'b0);
    nop(1);
    rd(2'd2, 4'd1, 1'b0);
    nop(CL + 2);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_multibank.md
DRAM_MULTIBANK -- requirements
Module: dram_multibank

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning data word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ROW_W, default 12, meaning row address bits.
REQ-003 The block SHALL have parameter COL_W, default 10, meaning column address bits.
REQ-004 The block SHALL have parameter BANK_W, default 2, meaning bank address bits (NUM_BANKS = 2**BANK_W).
REQ-005 The block SHALL have parameter CL, default 3, meaning CAS read latency in cycles (range 1..8).
REQ-006 The block SHALL have parameter TRCD, default 2, meaning the minimum number of cycles from ACTIVATE to a column command (range 1..15).
REQ-007 The block SHALL have the following ports (derived widths: ADDR_W = max(ROW_W, COL_W); BYTES = WORD_W/8):
- CK  in  1  clock, all state changes on rising edge
- RSTn  in  1  reset, asynchronous, active-low
- CSn  in  1  chip select, active-low
- RASn  in  1  row address strobe, active-low
- CASn  in  1  column address strobe, active-low
- WEn  in  BYTES  per-byte write enable, active-low
- BA  in  BANK_W  bank address
- A  in  ADDR_W  row or column address
- D  in  WORD_W  write data
- Q  out  WORD_W  read data
- QV  out  1  Q valid
- BANK_OPEN  out  NUM_BANKS  per-bank row-open flags
- CMD_ERR  out  1  one-cycle pulse on an illegal command

Function
REQ-008 Commands SHALL be decoded on the rising edge of CK only when CSn=0; CSn=1 SHALL be a NOP.
REQ-009 RASn=0, CASn=1 SHALL be ACTIVATE: if bank BA is closed, latch its open row from A[ROW_W-1:0], set BANK_OPEN[BA], and load that bank's tRCD counter with TRCD.
REQ-010 ACTIVATE to an already-open bank SHALL be ignored, with CMD_ERR=1 for the next cycle.
REQ-011 RASn=0, CASn=0 SHALL be a column command to bank BA at column A[COL_W-1:0] of that bank's open row.
REQ-012 A column command is a WRITE if any WEn bit is 0, otherwise a READ.
REQ-013 A column command to a closed bank, or to a bank whose tRCD counter is nonzero, SHALL be ignored (no write, no QV), with CMD_ERR=1 for the next cycle.
REQ-014 WRITE SHALL update exactly the bytes with WEn[i]=0 at the next edge.
REQ-015 READ SHALL produce the stored word on Q with QV=1 exactly CL cycles after the command edge.
REQ-016 Back-to-back READs SHALL produce back-to-back QV pulses in command order.
REQ-017 A READ issued the cycle after a WRITE to the same address SHALL return the new data.
REQ-018 When QV=0, Q SHALL be all-zero.
REQ-019 RASn=1, CASn=0 SHALL be PRECHARGE: clear BANK_OPEN[BA]; PRECHARGE to a closed bank SHALL be legal and cause no error.
REQ-020 A PRECHARGE SHALL NOT cancel READs already in the latency pipeline.
REQ-021 Each bank's tRCD counter SHALL decrement by 1 per cycle, saturating at 0.
REQ-022 Banks SHALL be fully independent, so ACTIVATE to bank 1 SHALL NOT affect bank 0's open row or counter.
REQ-023 RASn=1, CASn=1 with CSn=0 SHALL be a NOP.

Reset
REQ-024 When RSTn=0, the block SHALL asynchronously clear BANK_OPEN, all open-row registers, all tRCD counters, the read pipeline, Q, QV and CMD_ERR to 0.
REQ-025 Memory array contents SHALL NOT be cleared by reset.
REQ-026 Any READ in flight at reset SHALL be discarded.

Structure
REQ-027 Shared package dram_pkg SHALL hold the command enum (NOP, ACT, RD, WR, PRE) and the derived-width helper constants.
REQ-028 The CL-deep valid/data delay line SHALL be a sub-module named dram_rd_pipe, parametrised by WORD_W and CL.
REQ-029 Storage SHALL be one byte-lane array per byte, indexed by {bank, row, col}.

Verification
REQ-030 The bench (ROW_W=4, COL_W=4, BANK_W=2, CL=3, TRCD=2) SHALL cover the following directed scenarios:
- ACT b0 r5; wait 2; WR b0 c3 D=0xA5A5_1234 WEn=0000; RD b0 c3 -> QV=1 with Q=0xA5A5_1234 exactly 3 cycles after RD.
- WR all-zero word, then WR D=0xFFFF_FFFF WEn=1010, then RD -> Q=0x00FF_00FF.
- ACT b1 r2 then RD b1 the next cycle -> CMD_ERR pulse, no QV; RD 2 cycles after ACT succeeds.
- RD to closed bank 3 -> CMD_ERR=1 one cycle; ACT to open bank 0 -> CMD_ERR, row unchanged (verified by readback).
- Open b0 r5 and b2 r9; write distinct words; 4 back-to-back RDs alternating banks -> 4 consecutive QV cycles with correct order; PRE b0 mid-burst does not drop data.
- RSTn low with 2 RDs in flight -> QV/Q/BANK_OPEN go 0 immediately; after release, ACT+RD of the previously written address returns the pre-reset data.
